// File: rtl/bg_scroll_scheduler.sv
// bg_scroll_scheduler
// Frame-synchronous controller for the scrolling background renderer.
// Once per frame it advances a ground-layer scroll offset and a half-speed
// cloud-layer offset. It also steps a fade-in/fade-out FSM that drives the
// background enable and the colour intensity. Configuration writes go into
// pending registers and are copied to the active set only at frame start.
//
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   vsync          - raw vertical sync (asynchronous); rising edge = frame start
//   cfg_we         - register write strobe (one cycle)
//   cfg_addr       - register address (0 CTRL, 1 SPEED, 2 GROUND_SET, 3 STATUS)
//   cfg_wdata      - register write data
//   cfg_rdata      - combinational read data for cfg_addr
//   frame_tick     - one-cycle pulse per frame start
//   bg_en          - background enable to the pixel generator
//   fade_level     - colour intensity, 0 = black .. 3 = full
//   ground_x_off   - ground layer scroll offset, 0..H_RES-1
//   cloud_x_off    - cloud layer scroll offset, 0..H_RES-1
module bg_scroll_scheduler #(
    parameter int H_RES = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic       frame_tick,
    output logic       bg_en,
    output logic [1:0] fade_level,
    output logic [9:0] ground_x_off,
    output logic [9:0] cloud_x_off
);

    localparam logic [9:0]  H_RES_W  = 10'(H_RES);
    localparam logic [10:0] H_RES2_W = 11'(2 * H_RES);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_ON       = 2'd2,
        ST_FADE_OUT = 2'd3
    } fade_state_t;

    fade_state_t state;

    logic       vs_meta;
    logic       vs_sync;
    logic       vs_prev;
    logic [1:0] warm;
    logic       armed;

    logic [2:0] ctrl_pend;
    logic [7:0] speed_pend;
    logic [7:0] preset;
    logic       preset_flag;
    logic [2:0] ctrl_act;
    logic [7:0] speed_act;

    logic [3:0]  div_cnt;
    logic [3:0]  frame_cnt;
    logic [10:0] cloud_acc;

    logic [9:0]  ground_next;
    logic [10:0] cloud_next;
    logic [9:0]  step_g;
    logic [10:0] step_c;

    logic run_act;
    logic en_req_act;
    logic dir_act;

    assign run_act    = ctrl_act[0];
    assign en_req_act = ctrl_act[1];
    assign dir_act    = ctrl_act[2];

    // Synchronizer and edge detector. After reset the detector stays disarmed
    // until the synchronizer has refilled with real samples and has seen vsync
    // low, so a vsync that is already high at reset release cannot look like
    // a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_meta    <= 1'b0;
            vs_sync    <= 1'b0;
            vs_prev    <= 1'b0;
            warm       <= 2'b00;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_meta    <= vsync;
            vs_sync    <= vs_meta;
            vs_prev    <= vs_sync;
            warm       <= {warm[0], 1'b1};
            armed      <= armed | (warm[1] & ~vs_sync);
            frame_tick <= vs_sync & ~vs_prev & armed;
        end
    end

    // Register file. Writes land in the pending copies; the active copies only
    // move at frame_tick, and they take the pending value from before the edge,
    // so a write in the tick cycle waits for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_pend   <= 3'd0;
            speed_pend  <= 8'd0;
            preset      <= 8'd0;
            preset_flag <= 1'b0;
            ctrl_act    <= 3'd0;
            speed_act   <= 8'd0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    ctrl_pend  <= cfg_wdata[2:0];
                    2'd1:    speed_pend <= cfg_wdata;
                    2'd2:    preset     <= cfg_wdata;
                    default: ;
                endcase
            end
            if (cfg_we && cfg_addr == 2'd2) begin
                preset_flag <= 1'b1;
            end else if (frame_tick) begin
                preset_flag <= 1'b0;
            end
            if (frame_tick) begin
                ctrl_act  <= ctrl_pend;
                speed_act <= speed_pend;
            end
        end
    end

    // Modular step arithmetic, kept at the register width: the wrap tests are
    // arranged so no intermediate ever needs an extra bit.
    always_comb begin
        step_g = {6'd0, speed_act[3:0]};
        step_c = {7'd0, speed_act[3:0]};
        if (!dir_act) begin
            if (ground_x_off >= H_RES_W - step_g)
                ground_next = ground_x_off + step_g - H_RES_W;
            else
                ground_next = ground_x_off + step_g;
            if (cloud_acc >= H_RES2_W - step_c)
                cloud_next = cloud_acc + step_c - H_RES2_W;
            else
                cloud_next = cloud_acc + step_c;
        end else begin
            if (ground_x_off < step_g)
                ground_next = ground_x_off + H_RES_W - step_g;
            else
                ground_next = ground_x_off - step_g;
            if (cloud_acc < step_c)
                cloud_next = cloud_acc + H_RES2_W - step_c;
            else
                cloud_next = cloud_acc - step_c;
        end
    end

    // Scroll offsets and frame divider. A pending preset wins over the step
    // for that tick. The divider only counts while running and restarts
    // whenever the divisor is about to change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ground_x_off <= 10'd0;
            cloud_acc    <= 11'd0;
            div_cnt      <= 4'd0;
            frame_cnt    <= 4'd0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 4'd1;
            if (preset_flag) begin
                ground_x_off <= {2'b00, preset};
                cloud_acc    <= {2'b00, preset, 1'b0};
            end else if (run_act && div_cnt == speed_act[7:4]) begin
                ground_x_off <= ground_next;
                cloud_acc    <= cloud_next;
            end
            if (speed_pend[7:4] != speed_act[7:4]) begin
                div_cnt <= 4'd0;
            end else if (run_act) begin
                if (div_cnt == speed_act[7:4])
                    div_cnt <= 4'd0;
                else
                    div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    assign cloud_x_off = cloud_acc[10:1];

    // Fade sequencer. Leaving FADE_IN early keeps the current level, and the
    // level-0/1 check in FADE_OUT lets a fade that never got above 0 still
    // drop back to OFF on the next tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            fade_level <= 2'd0;
            bg_en      <= 1'b0;
        end else if (frame_tick) begin
            case (state)
                ST_OFF: begin
                    if (en_req_act) begin
                        state      <= ST_FADE_IN;
                        fade_level <= 2'd0;
                        bg_en      <= 1'b1;
                    end
                end
                ST_FADE_IN: begin
                    if (!en_req_act) begin
                        state <= ST_FADE_OUT;
                    end else if (fade_level >= 2'd2) begin
                        state      <= ST_ON;
                        fade_level <= 2'd3;
                    end else begin
                        fade_level <= fade_level + 2'd1;
                    end
                end
                ST_ON: begin
                    if (!en_req_act) begin
                        state <= ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    if (en_req_act) begin
                        state <= ST_FADE_IN;
                    end else if (fade_level <= 2'd1) begin
                        state      <= ST_OFF;
                        fade_level <= 2'd0;
                        bg_en      <= 1'b0;
                    end else begin
                        fade_level <= fade_level - 2'd1;
                    end
                end
                default: begin
                    state      <= ST_OFF;
                    fade_level <= 2'd0;
                    bg_en      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = {5'd0, ctrl_pend};
            2'd1:    cfg_rdata = speed_pend;
            2'd2:    cfg_rdata = preset;
            default: cfg_rdata = {state, fade_level, frame_cnt};
        endcase
    end

endmodule
